// File: rtl/adder_pkg.sv
// adder_pkg: shared configuration helpers for the pipelined carry-ripple adder.
//   chunk_width(w, s) : bits rippled per pipeline stage
//   cfg_legal(w, s)   : elaboration-time legality of a WIDTH/STAGES pair
package adder_pkg;

    function automatic int chunk_width(input int w, input int s);
        return w / s;
    endfunction

    function automatic bit cfg_legal(input int w, input int s);
        return (s >= 1) && (s <= w) && ((w % s) == 0);
    endfunction

endpackage

// File: rtl/adder_stage.sv
// adder_stage: one C-bit ripple chunk (bits [K*C +: C]) plus its pipeline register.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   en               global advance; register holds when low
//   in_v/out_v       stage valid
//   in_a/out_a       operand A (full width, upper bits still to be added)
//   in_b/out_b       operand B, already inverted for subtraction
//   in_s/out_s       partial sum; bits below this chunk already final
//   in_c/out_c       chunk carry in / registered carry out
module adder_stage #(
    parameter int WIDTH = 8,
    parameter int C     = 4,
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_v,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_s,
    input  logic             in_c,
    output logic             out_v,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_s,
    output logic             out_c
);

    logic [C:0]       cc;
    logic [WIDTH-1:0] ns;

    always_comb begin
        ns    = in_s;
        cc    = '0;
        cc[0] = in_c;
        for (int i = 0; i < C; i++) begin
            ns[K*C+i] = in_a[K*C+i] ^ in_b[K*C+i] ^ cc[i];
            cc[i+1]   = (in_a[K*C+i] & in_b[K*C+i]) | (cc[i] & (in_a[K*C+i] ^ in_b[K*C+i]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_v <= 1'b0;
            out_a <= '0;
            out_b <= '0;
            out_s <= '0;
            out_c <= 1'b0;
        end else if (en) begin
            out_v <= in_v;
            out_a <= in_a;
            out_b <= in_b;
            out_s <= ns;
            out_c <= cc[C];
        end
    end

endmodule

// File: rtl/pipelined_cr_adder.sv
// pipelined_cr_adder: WIDTH-bit add/sub split into STAGES registered ripple chunks.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid, in_ready   operand handshake (in_ready does not depend on in_valid)
//   x, y, sub            operands; sub=1 computes x-y
//   out_valid, out_ready result handshake
//   sum, carry           result; for sub, carry=1 means no borrow
//   ovf                  signed overflow, present only when ADDER_OVF_FLAG_EN is defined
module pipelined_cr_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef ADDER_OVF_FLAG_EN
    output logic             ovf,
`endif
    output logic             carry
);

    localparam int C = chunk_width(WIDTH, STAGES);

    if (!cfg_legal(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_cr_adder: WIDTH must be a multiple of STAGES, STAGES in 1..WIDTH");
    end

    logic             adv;
    logic             v_c [STAGES+1];
    logic [WIDTH-1:0] a_c [STAGES+1];
    logic [WIDTH-1:0] b_c [STAGES+1];
    logic [WIDTH-1:0] s_c [STAGES+1];
    logic             c_c [STAGES+1];

    // The whole pipe moves together; a stalled output freezes every stage.
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    assign v_c[0] = in_valid;
    assign a_c[0] = x;
    assign b_c[0] = sub ? ~y : y;
    assign s_c[0] = '0;
    assign c_c[0] = sub;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_stage #(.WIDTH(WIDTH), .C(C), .K(k)) u_stage (
            .clk   (clk),
            .rst   (rst),
            .en    (adv),
            .in_v  (v_c[k]),
            .in_a  (a_c[k]),
            .in_b  (b_c[k]),
            .in_s  (s_c[k]),
            .in_c  (c_c[k]),
            .out_v (v_c[k+1]),
            .out_a (a_c[k+1]),
            .out_b (b_c[k+1]),
            .out_s (s_c[k+1]),
            .out_c (c_c[k+1])
        );
    end

    assign out_valid = v_c[STAGES];
    assign sum       = s_c[STAGES];
    assign carry     = c_c[STAGES];

`ifdef ADDER_OVF_FLAG_EN
    // Carry-in(MSB) ^ carry-out(MSB) reduces to: equal operand MSBs and a sum MSB that differs.
    // Built from the final registers, so it resets to 0 and holds with sum.
    assign ovf = (a_c[STAGES][WIDTH-1] == b_c[STAGES][WIDTH-1]) &
                 (s_c[STAGES][WIDTH-1] != a_c[STAGES][WIDTH-1]);
`endif

endmodule

// File: tb/tb_pipelined_cr_adder.sv
// tb_pipelined_cr_adder: randomized + directed bench against an arithmetic reference model.
module tb_pipelined_cr_adder;

    localparam int W = 8;
    localparam int S = 2;
`ifdef ADDER_OVF_FLAG_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, sub, out_valid, out_ready, carry;
    logic [W-1:0] x, y, sum;
    logic         dov;
    logic [9:0]   dut_res;
    logic [9:0]   q[$];
    logic [9:0]   held;
    logic         held_v;
    int           vectors = 0;
    int           miscompares = 0;

`ifdef ADDER_OVF_FLAG_EN
    logic ovf;
    assign dov = ovf;
`else
    assign dov = 1'b0;
`endif
    assign dut_res = {dov, carry, sum};

    pipelined_cr_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef ADDER_OVF_FLAG_EN
        .ovf       (ovf),
`endif
        .carry     (carry)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, {ovf, carry, sum}.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
        int  r  = s ? int'(a) - int'(b) : int'(a) + int'(b);
        int  sr = s ? int'($signed(a)) - int'($signed(b)) : int'($signed(a)) + int'($signed(b));
        logic c = s ? (a >= b) : (r > 255);
        logic o = (sr > 127) || (sr < -128);
        return {o & OVF_ON, c, r[7:0]};
    endfunction

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Single isolated transaction: pins the model to a literal and measures latency.
    task automatic directed(input logic [7:0] xx, input logic [7:0] yy, input logic ss, input logic [9:0] exp);
        int n;
        chk("model_literal", 16'(model(xx, yy, ss)), 16'(exp));
        x = xx; y = yy; sub = ss; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        n = 1;
        #1 in_valid = 1'b0;
        while (!out_valid && n < 10) begin
            cyc();
            n++;
        end
        chk("directed_latency", 16'(n), 16'(S));
        chk("directed_result", 16'(dut_res), 16'(exp));
        cyc();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("spurious_out", 16'(out_valid), 16'd0);
                else chk("stream_result", 16'(dut_res), 16'(q.pop_front()));
            end
            if (out_valid && !out_ready) begin
                if (held_v) chk("hold", 16'(dut_res), 16'(held));
                held   = dut_res;
                held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
            if (in_valid && in_ready) q.push_back(model(x, y, sub));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; x = '0; y = '0; sub = 1'b0; out_ready = 1'b1;
        #1 rst = 1'b1;
        #10;
        chk("reset_out_valid", 16'(out_valid), 16'd0);
        chk("reset_sum", 16'(sum), 16'd0);
        chk("reset_carry", 16'(carry), 16'd0);
        chk("reset_ovf", 16'(dov), 16'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("ready_after_reset", 16'(in_ready), 16'd1);
        cyc();
        directed(8'hFF, 8'h01, 1'b0, 10'h100);
        directed(8'h05, 8'h07, 1'b1, 10'h0FE);
        directed(8'h07, 8'h05, 1'b1, 10'h102);
`ifdef ADDER_OVF_FLAG_EN
        directed(8'h7F, 8'h01, 1'b0, 10'h280);
        directed(8'h80, 8'h01, 1'b1, 10'h37F);
        directed(8'h10, 8'h01, 1'b0, 10'h011);
`endif
        for (int i = 0; i < 26; i++) begin
            x = W'($urandom); y = W'($urandom); sub = 1'($urandom_range(0, 1)); in_valid = 1'b1;
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            x = W'($urandom); y = W'($urandom); sub = 1'($urandom_range(0, 1));
            cyc();
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_in_ready", 16'(in_ready), 16'd0);
            x = W'($urandom); y = W'($urandom);
            cyc();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            x = W'($urandom); y = W'($urandom); sub = 1'($urandom_range(0, 1));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (S + 4) cyc();
        chk("drain_empty", 16'(q.size()), 16'd0);
        x = 8'h11; y = 8'h22; sub = 1'b0; in_valid = 1'b1;
        cyc();
        x = 8'h33; y = 8'h44;
        cyc();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 chk("reset_flush_valid", 16'(out_valid), 16'd0);
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("no_stale_after_reset", 16'(out_valid), 16'd0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
